wu_decode: RTL

WU_DECODE -- requirements
Module: wu_decode

---
 rtl/wu_decode_pkg.sv | 35 +++
 rtl/wu_decode_fifo.sv | 65 ++++++
 rtl/wu_decode.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/wu_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wu_decode_pkg
//  Description : Shared definitions for the WU decode block. Holds the
//                instruction delineator codes, option-type codes, field
//                widths and the decoded-instruction record.
//  Revision    : 1.0 - initial release
// ============================================================================
package wu_decode_pkg;

    localparam int FIELD_W    = 16;
    localparam int OPT_TYPE_W = 4;
    localparam int ICNTL_W    = 2;

    // Instruction delineator codes
    localparam logic [ICNTL_W-1:0] c_ICNTL_MOM     = 2'b00;
    localparam logic [ICNTL_W-1:0] c_ICNTL_SOM     = 2'b01;
    localparam logic [ICNTL_W-1:0] c_ICNTL_EOM     = 2'b10;
    localparam logic [ICNTL_W-1:0] c_ICNTL_SOM_EOM = 2'b11;

    // Option types; every other code is ignored
    localparam logic [OPT_TYPE_W-1:0] c_OPT_OP    = 4'd1;
    localparam logic [OPT_TYPE_W-1:0] c_OPT_SRC   = 4'd2;
    localparam logic [OPT_TYPE_W-1:0] c_OPT_DEST  = 4'd3;
    localparam logic [OPT_TYPE_W-1:0] c_OPT_NOPS  = 4'd4;

    typedef struct packed {
        logic [FIELD_W-1:0] op;
        logic [FIELD_W-1:0] src_addr;
        logic [FIELD_W-1:0] dest_addr;
        logic [FIELD_W-1:0] num_operands;
    } wu_fields_t;

endpackage
`default_nettype wire

// File: rtl/wu_decode_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wu_decode_fifo
//  Description : Input entry buffer for the WU decoder. Pushes are ignored
//                while full and pops are ignored while empty, so callers may
//                present raw requests. Head entry is visible on o_data.
//  Ports       : clk, reset_poweron (async, active-low)
//                i_push/i_data  - write request and entry
//                i_pop          - consume head entry
//                o_data         - head entry
//                o_full/o_empty - status, o_count - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module wu_decode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    // Storage needs no reset: only entries covered by r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/wu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : wu_decode
//  Description : Assembles multi-entry WU instructions (SOM/MOM/EOM framed)
//                into decoded op/src/dest/num_operands fields, presented
//                with a valid/ready handshake.
//  Ports       : clk, reset_poweron (async, active-low)
//                wum__wud__*  - WU memory entry (valid, delineator, options)
//                wud__wuf__stall - registered backpressure to fetch
//                wud__xxx__*  - decoded instruction, valid, error pulse
//                xxx__wud__ready - consumer accept
//  Revision    : 1.0 - initial release
// ============================================================================
module wu_decode
    import wu_decode_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int OPT_PER_INST = 3
) (
    input  logic                               clk,
    input  logic                               reset_poweron,
    input  logic                               wum__wud__valid,
    input  logic [ICNTL_W-1:0]                 wum__wud__icntl,
    input  logic [OPT_TYPE_W*OPT_PER_INST-1:0] wum__wud__option_type,
    input  logic [FIELD_W*OPT_PER_INST-1:0]    wum__wud__option_value,
    output logic                               wud__wuf__stall,
    output logic                               wud__xxx__valid,
    input  logic                               xxx__wud__ready,
    output logic [FIELD_W-1:0]                 wud__xxx__op,
    output logic [FIELD_W-1:0]                 wud__xxx__src_addr,
    output logic [FIELD_W-1:0]                 wud__xxx__dest_addr,
    output logic [FIELD_W-1:0]                 wud__xxx__num_operands,
    output logic                               wud__xxx__error
);

    localparam int c_TYPES_W = OPT_TYPE_W * OPT_PER_INST;
    localparam int c_VALS_W  = FIELD_W * OPT_PER_INST;
    localparam int c_ENTRY_W = ICNTL_W + c_VALS_W + c_TYPES_W;
    localparam int c_CW      = $clog2(FIFO_DEPTH) + 1;
    // Two entries of headroom cover those already in flight from fetch.
    localparam logic [c_CW-1:0] c_STALL_LVL = c_CW'(FIFO_DEPTH - 2);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    logic [c_ENTRY_W-1:0] w_head;
    logic [ICNTL_W-1:0]   w_head_icntl;
    logic [c_TYPES_W-1:0] w_head_type;
    logic [c_VALS_W-1:0]  w_head_val;
    logic                 w_full;
    logic                 w_empty;
    logic [c_CW-1:0]      w_count;
    logic [c_CW-1:0]      w_count_nxt;
    logic                 w_push_acc;
    logic                 w_overflow;
    logic                 w_pop;
    logic                 w_bad_delim;
    logic                 w_load;
    logic                 w_clear;
    logic [1:0]           w_state_nxt;
    wu_fields_t           w_fields_nxt;

    logic [1:0]           r_state;
    wu_fields_t           r_fields;
    logic                 r_stall;
    logic                 r_error;

    wu_decode_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .i_push        (wum__wud__valid),
        .i_data        ({wum__wud__icntl, wum__wud__option_value, wum__wud__option_type}),
        .i_pop         (w_pop),
        .o_data        (w_head),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_count       (w_count)
    );

    assign w_head_type  = w_head[c_TYPES_W-1:0];
    assign w_head_val   = w_head[c_TYPES_W +: c_VALS_W];
    assign w_head_icntl = w_head[c_ENTRY_W-1 -: ICNTL_W];

    assign w_push_acc  = wum__wud__valid & ~w_full;
    assign w_overflow  = wum__wud__valid &  w_full;
    assign w_count_nxt = w_count + c_CW'(w_push_acc) - c_CW'(w_pop);

    // Sequencing of delineators
    always_comb begin
        w_pop       = (r_state != c_ST_HOLD) && !w_empty;
        w_state_nxt = r_state;
        w_bad_delim = 1'b0;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_ACCUM: begin
                if (w_pop) begin
                    case (w_head_icntl)
                        c_ICNTL_SOM, c_ICNTL_SOM_EOM: begin
                            // A start inside an open instruction abandons it.
                            w_bad_delim = (r_state == c_ST_ACCUM);
                            w_clear     = 1'b1;
                            w_load      = 1'b1;
                            w_state_nxt = (w_head_icntl == c_ICNTL_SOM_EOM) ? c_ST_HOLD : c_ST_ACCUM;
                        end
                        default: begin
                            if (r_state == c_ST_ACCUM) begin
                                w_load = 1'b1;
                                if (w_head_icntl == c_ICNTL_EOM) w_state_nxt = c_ST_HOLD;
                            end else begin
                                w_bad_delim = 1'b1;
                            end
                        end
                    endcase
                end
            end
            c_ST_HOLD: begin
                if (xxx__wud__ready) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Option application; later slots of the same type win.
    always_comb begin
        w_fields_nxt = w_clear ? '0 : r_fields;
        for (int i = 0; i < OPT_PER_INST; i++) begin
            case (w_head_type[i*OPT_TYPE_W +: OPT_TYPE_W])
                c_OPT_OP:   w_fields_nxt.op           = w_head_val[i*FIELD_W +: FIELD_W];
                c_OPT_SRC:  w_fields_nxt.src_addr     = w_head_val[i*FIELD_W +: FIELD_W];
                c_OPT_DEST: w_fields_nxt.dest_addr    = w_head_val[i*FIELD_W +: FIELD_W];
                c_OPT_NOPS: w_fields_nxt.num_operands = w_head_val[i*FIELD_W +: FIELD_W];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_state  <= c_ST_IDLE;
            r_fields <= '0;
            r_stall  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) r_fields <= w_fields_nxt;
            // Registered from next occupancy so stall tracks the FIFO level
            // in the same cycle the level is reached.
            r_stall <= (w_count_nxt >= c_STALL_LVL);
            // Overflow and bad delineator merge into one pulse.
            r_error <= w_overflow | w_bad_delim;
        end
    end

    assign wud__wuf__stall        = r_stall;
    assign wud__xxx__valid        = (r_state == c_ST_HOLD);
    assign wud__xxx__error        = r_error;
    assign wud__xxx__op           = r_fields.op;
    assign wud__xxx__src_addr     = r_fields.src_addr;
    assign wud__xxx__dest_addr    = r_fields.dest_addr;
    assign wud__xxx__num_operands = r_fields.num_operands;

endmodule
`default_nettype wire
